// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// State encoding, add-3 correction values and digit sizing.
package bcd_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit add-3 corrector applied before each double-dabble shift.
// Purely combinational; the 4-bit sum wraps with no carry out.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_ADJ_THRESH) begin
      digit_o = digit_i + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter.
// One conversion per WIDTH shift cycles under a start/busy/done handshake.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      CLOCK_50,
  input  logic                      RST,
  input  logic                      START,
  input  logic [WIDTH-1:0]          BIN,
  output logic [DIGIT_W*DIGITS-1:0] BCD,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be 1..16");
  end

  if (pow10(DIGITS) <= (longint'(1) << WIDTH) - 1) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   out_q, out_d;
  logic            done_q, done_d;
  logic [BW-1:0]   adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i(bcd_q[DIGIT_W*g +: DIGIT_W]),
      .digit_o(adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          bin_d   = BIN;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
        cnt_d = cnt_q - 1'b1;
        // last shift: publish the freshly shifted digits
        if (cnt_q == CW'(1)) begin
          out_d   = {adj[BW-2:0], bin_q[WIDTH-1]};
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign BCD  = out_q;
  assign DONE = done_q;
  assign BUSY = (state_q == S_SHIFT);

endmodule
